// File: rtl/fpconv_pkg.sv
// Shared constants and state encoding for the round-robin converter scheduler.
package fpconv_pkg;

    localparam int FPC_DATA_W = 12;
    localparam int FPC_EXP_W  = 3;
    localparam int FPC_FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/fpconv_rr_scheduler_if.sv
// Request, result and handshake bundle between the sample front-end, the
// scheduler (slave) and the consumer; the bench/front-end side uses master.
interface fpconv_rr_scheduler_if;
    import fpconv_pkg::*;

    logic                         req0_valid;
    logic signed [FPC_DATA_W-1:0] req0_data;
    logic                         req0_ready;
    logic                         req1_valid;
    logic signed [FPC_DATA_W-1:0] req1_data;
    logic                         req1_ready;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_s;
    logic [FPC_EXP_W-1:0]         out_e;
    logic [FPC_FRAC_W-1:0]        out_f;
    logic                         out_id;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_s, out_e, out_f, out_id
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_s, out_e, out_f, out_id
    );

endinterface

// File: rtl/floating_point_converter.sv
// Combinational 12-bit two's-complement to sign/exponent/significand converter
// with round-half-up on the significand and saturation at the top exponent.
module floating_point_converter #(
    parameter int DATA_W = 12,
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4
) (
    input  logic signed [DATA_W-1:0] d,
    output logic                     s,
    output logic [EXP_W-1:0]         e,
    output logic [FRAC_W-1:0]        f
);

    logic [DATA_W-1:0] mag;
    logic [EXP_W-1:0]  e_raw;
    logic [DATA_W:0]   ext;
    logic [FRAC_W-1:0] f_raw;
    logic              rnd;

    function automatic logic [EXP_W+FRAC_W-1:0] round_sat(
        input logic [EXP_W-1:0]  e_in,
        input logic [FRAC_W-1:0] f_in,
        input logic              rnd_in
    );
        logic [FRAC_W:0]             sum;
        logic [EXP_W+FRAC_W-1:0]     res;
        sum = {1'b0, f_in} + (FRAC_W+1)'(rnd_in);
        if (!sum[FRAC_W])
            res = {e_in, sum[FRAC_W-1:0]};
        else if (e_in == {EXP_W{1'b1}})
            res = {e_in, {FRAC_W{1'b1}}};
        else
            res = {e_in + EXP_W'(1), 1'b1, {(FRAC_W-1){1'b0}}};
        return res;
    endfunction

    always_comb begin
        s   = d[DATA_W-1];
        mag = s ? DATA_W'(-d) : DATA_W'(d);
        // only the most negative sample leaves the top bit set after negation
        if (mag[DATA_W-1])
            mag = {1'b0, {(DATA_W-1){1'b1}}};
        e_raw = '0;
        for (int i = FRAC_W; i < DATA_W - 1; i++)
            if (mag[i]) e_raw = EXP_W'(i - FRAC_W + 1);
        // one extra low bit so the rounding bit falls out of the same shift
        ext   = {mag, 1'b0} >> e_raw;
        f_raw = FRAC_W'(ext >> 1);
        rnd   = ext[0];
        {e, f} = round_sat(e_raw, f_raw, rnd);
    end

endmodule

// File: rtl/fpconv_rr_scheduler.sv
// Round-robin sharing of one floating_point_converter between two requesters.
// Optional macro FPCONV_STATS_EN adds a 16-bit completed-result counter port.
module fpconv_rr_scheduler
    import fpconv_pkg::*;
#(
    parameter int DATA_W = FPC_DATA_W,
    parameter int EXP_W  = FPC_EXP_W,
    parameter int FRAC_W = FPC_FRAC_W
) (
    input logic                  clk,
    input logic                  rst,
    fpconv_rr_scheduler_if.slave bus
`ifdef FPCONV_STATS_EN
    ,
    output logic [15:0]          conv_count
`endif
);

    state_t                   state;
    state_t                   state_nxt;
    logic signed [DATA_W-1:0] d_reg;
    logic                     id_reg;
    logic                     last_grant;
    logic                     grant;
    logic                     grant_id;
    logic                     req0_rdy;
    logic                     req1_rdy;
    logic                     res_valid;
    logic                     res_s;
    logic [EXP_W-1:0]         res_e;
    logic [FRAC_W-1:0]        res_f;
    logic                     res_id;
    logic                     conv_s;
    logic [EXP_W-1:0]         conv_e;
    logic [FRAC_W-1:0]        conv_f;
    logic                     accept;

    floating_point_converter #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_conv (
        .d (d_reg),
        .s (conv_s),
        .e (conv_e),
        .f (conv_f)
    );

    assign accept = res_valid && bus.out_ready;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = ID_REQ0;
        req0_rdy  = 1'b0;
        req1_rdy  = 1'b0;
        case (state)
            IDLE: begin
                // on contention the requester not served last time wins
                if (bus.req0_valid && bus.req1_valid) begin
                    grant    = 1'b1;
                    grant_id = ~last_grant;
                end else if (bus.req0_valid) begin
                    grant    = 1'b1;
                    grant_id = ID_REQ0;
                end else if (bus.req1_valid) begin
                    grant    = 1'b1;
                    grant_id = ID_REQ1;
                end
                if (grant) begin
                    state_nxt = CONV;
                    req0_rdy  = (grant_id == ID_REQ0);
                    req1_rdy  = (grant_id == ID_REQ1);
                end
            end
            CONV:    state_nxt = OUT;
            OUT:     if (accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            d_reg      <= '0;
            id_reg     <= ID_REQ0;
            last_grant <= ID_REQ1;
            res_valid  <= 1'b0;
            res_s      <= 1'b0;
            res_e      <= '0;
            res_f      <= '0;
            res_id     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                d_reg      <= (grant_id == ID_REQ1) ? bus.req1_data : bus.req0_data;
                id_reg     <= grant_id;
                last_grant <= grant_id;
            end
            if (state == CONV) begin
                res_s     <= conv_s;
                res_e     <= conv_e;
                res_f     <= conv_f;
                res_id    <= id_reg;
                res_valid <= 1'b1;
            end
            if (state == OUT && accept)
                res_valid <= 1'b0;
        end
    end

`ifdef FPCONV_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conv_count <= '0;
        else if (accept)
            conv_count <= conv_count + 16'd1;
    end
`endif

    assign bus.req0_ready = req0_rdy;
    assign bus.req1_ready = req1_rdy;
    assign bus.out_valid  = res_valid;
    assign bus.out_s      = res_s;
    assign bus.out_e      = res_e;
    assign bus.out_f      = res_f;
    assign bus.out_id     = res_id;

endmodule

// File: tb/tb_fpconv_rr_scheduler.sv
// Bench for fpconv_rr_scheduler: fixed vectors, reset corner cases and random
// traffic against an arithmetic conversion / round-robin model.
module tb_fpconv_rr_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_last;
    int   m_count;

    always #5 clk = ~clk;

    fpconv_rr_scheduler_if ifc ();

`ifdef FPCONV_STATS_EN
    logic [15:0] conv_count;
`endif

    fpconv_rr_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef FPCONV_STATS_EN
        ,
        .conv_count (conv_count)
`endif
    );

    typedef struct {
        logic        v0;
        logic [11:0] d0;
        logic        v1;
        logic [11:0] d1;
        int          bp;
        logic        id;
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // {s, e[2:0], f[3:0]} derived from the magnitude with plain integer math
    function automatic logic [7:0] ref_conv(input logic [11:0] d);
        int   mag, e, f, p;
        logic s;
        s   = d[11];
        mag = int'(d);
        if (s) mag = 4096 - mag;
        if (mag > 2047) mag = 2047;
        if (mag < 16) begin
            e = 0;
            f = mag;
        end else begin
            p = 0;
            while ((1 << (p + 1)) <= mag) p++;
            e = p - 3;
            f = (mag + (1 << (e - 1))) >> e;
            if (f == 16) begin
                if (e == 7) f = 15;
                else begin
                    f = 8;
                    e = e + 1;
                end
            end
        end
        return {s, 3'(e), 4'(f)};
    endfunction

    task automatic do_txn(input string tag, input logic v0, input logic [11:0] d0,
                          input logic v1, input logic [11:0] d1, input int bp,
                          input logic exp_id, input logic [7:0] exp_res);
        bit         got;
        logic [8:0] held;
        @(posedge clk); #1;
        ifc.req0_valid = v0;
        ifc.req0_data  = d0;
        ifc.req1_valid = v1;
        ifc.req1_data  = d1;
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge clk);
            if (ifc.req0_ready || ifc.req1_ready) got = 1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s grant: no ready within 8 cycles, required one", tag);
            ifc.req0_valid = 0;
            ifc.req1_valid = 0;
            return;
        end
        check({tag, " grant"}, {ifc.req1_ready, ifc.req0_ready}, exp_id ? 2 : 1);
        m_last = exp_id;
        @(posedge clk); #1;
        ifc.req0_valid = 0;
        ifc.req1_valid = 0;
        @(negedge clk);
        check({tag, " conv"}, {ifc.out_valid, ifc.req1_ready, ifc.req0_ready}, 0);
        @(negedge clk);
        check({tag, " valid"}, ifc.out_valid, 1);
        check({tag, " result"}, {ifc.out_id, ifc.out_s, ifc.out_e, ifc.out_f}, {exp_id, exp_res});
        held = {ifc.out_id, ifc.out_s, ifc.out_e, ifc.out_f};
        for (int c = 0; c < bp; c++) begin
            if (c == 0) begin
                ifc.req0_valid = 1;
                ifc.req1_valid = 1;
            end
            @(negedge clk);
            check({tag, " hold"},
                  {ifc.out_valid, ifc.req1_ready, ifc.req0_ready, ifc.out_id, ifc.out_s, ifc.out_e, ifc.out_f},
                  {3'b100, held});
        end
        ifc.req0_valid = 0;
        ifc.req1_valid = 0;
        ifc.out_ready  = 1;
        @(posedge clk); #1;
        ifc.out_ready = 0;
        m_count++;
        @(negedge clk);
        check({tag, " drop"}, ifc.out_valid, 0);
`ifdef FPCONV_STATS_EN
        check({tag, " count"}, conv_count, m_count[15:0]);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 12'h000, 1'b1, 12'h001, 0,  1'b1, 1'b0, 3'd0, 4'b0001};
        tbl[1] = '{1'b1, 12'h02C, 1'b1, 12'h02E, 0,  1'b0, 1'b0, 3'd2, 4'b1011};
        tbl[2] = '{1'b1, 12'h02C, 1'b1, 12'h02E, 0,  1'b1, 1'b0, 3'd2, 4'b1100};
        tbl[3] = '{1'b1, 12'h07D, 1'b0, 12'h000, 0,  1'b0, 1'b0, 3'd4, 4'b1000};
        tbl[4] = '{1'b0, 12'h000, 1'b1, 12'h800, 2,  1'b1, 1'b1, 3'd7, 4'b1111};
        tbl[5] = '{1'b1, 12'h7FF, 1'b0, 12'h000, 10, 1'b0, 1'b0, 3'd7, 4'b1111};
        tbl[6] = '{1'b1, 12'h001, 1'b1, 12'hFFF, 1,  1'b1, 1'b1, 3'd0, 4'b0001};
        tbl[7] = '{1'b1, 12'h100, 1'b1, 12'hF00, 0,  1'b0, 1'b0, 3'd5, 4'b1000};

        rst            = 1;
        ifc.req0_valid = 0;
        ifc.req0_data  = '0;
        ifc.req1_valid = 0;
        ifc.req1_data  = '0;
        ifc.out_ready  = 0;
        m_last         = 1;
        m_count        = 0;

        @(negedge clk);
        check("reset outputs", {ifc.out_valid, ifc.out_s, ifc.out_e, ifc.out_f, ifc.out_id}, 0);
        check("reset ready", {ifc.req1_ready, ifc.req0_ready}, 0);
`ifdef FPCONV_STATS_EN
        check("reset count", conv_count, 0);
`endif
        @(posedge clk); #1;
        rst = 0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle no request", {ifc.out_valid, ifc.req1_ready, ifc.req0_ready}, 0);
        end

        for (int i = 0; i < 8; i++)
            do_txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1,
                   tbl[i].bp, tbl[i].id, {tbl[i].s, tbl[i].e, tbl[i].f});

        // asynchronous reset while a result is held in OUT
        @(posedge clk); #1;
        ifc.req0_valid = 1;
        ifc.req0_data  = 12'h7FF;
        @(negedge clk);
        check("async grant", {ifc.req1_ready, ifc.req0_ready}, 1);
        @(posedge clk); #1;
        ifc.req0_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("async held valid", ifc.out_valid, 1);
        #2 rst = 1;
        #1;
        check("async clear", {ifc.out_valid, ifc.out_s, ifc.out_e, ifc.out_f, ifc.out_id}, 0);
        check("async ready", {ifc.req1_ready, ifc.req0_ready}, 0);
        @(posedge clk); #1;
        rst = 0;
        m_last  = 1;
        m_count = 0;

        // reset during CONV after serving requester 0
        @(posedge clk); #1;
        ifc.req0_valid = 1;
        ifc.req0_data  = 12'h07D;
        @(negedge clk);
        check("conv-rst grant", {ifc.req1_ready, ifc.req0_ready}, 1);
        @(posedge clk); #1;
        ifc.req0_valid = 0;
        rst = 1;
        #1;
        check("conv-rst valid", ifc.out_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        m_last  = 1;
        m_count = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("conv-rst no pulse", ifc.out_valid, 0);
        end
        do_txn("post-rst contention", 1'b1, 12'h0AA, 1'b1, 12'h0BB, 0, 1'b0, ref_conv(12'h0AA));

        for (int i = 0; i < 40; i++) begin
            logic        rv0, rv1, eid;
            logic [11:0] rd0, rd1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1;
            rd0 = 12'($urandom);
            rd1 = 12'($urandom);
            if (i == 0) rd0 = 12'h800;
            eid = (rv0 && rv1) ? !m_last : rv1;
            do_txn($sformatf("rnd%0d", i), rv0, rd0, rv1, rd1, int'($urandom_range(0, 3)),
                   eid, ref_conv(eid ? rd1 : rd0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpconv_rr_scheduler.md
Name: fpconv_rr_scheduler

Overview:
- Shares one `floating_point_converter` instance (12-bit two's-complement in; S/E/F out) between two requesters.
- Uses round-robin arbitration with a valid/ready handshake on each request port and on the result port.
- Captures the granted sample, registers the converter result, and holds it with the requester ID until the consumer accepts it.
- Sits between the switch/sample front-end and the display/consumer logic.

Parameters:
- DATA_W, 12, input sample width; must match the converter.
- EXP_W, 3, exponent width.
- FRAC_W, 4, significand width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a sample.
- req0_data  in  DATA_W  requester 0 sample, two's complement.
- req0_ready  out  1  requester 0 sample accepted this cycle.
- req1_valid  in  1  requester 1 has a sample.
- req1_data  in  DATA_W  requester 1 sample.
- req1_ready  out  1  requester 1 sample accepted this cycle.
- out_valid  out  1  result held on out_* is valid.
- out_ready  in  1  consumer accepts the result.
- out_s  out  1  sign.
- out_e  out  EXP_W  exponent.
- out_f  out  FRAC_W  significand.
- out_id  out  1  requester that produced the result.

Behaviour:
- Reset is asynchronous and active-high. All flops clear immediately, independent of clk.
- Values on reset:
  - state=IDLE; out_valid=0; out_s=0, out_e=0, out_f=0, out_id=0.
  - d_reg=0; last_grant=1, so requester 0 wins the first contention.
- FSM states: IDLE, CONV, OUT.
- IDLE:
  - If only one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - The grant drives reqN_ready=1 combinationally in that cycle only.
  - On the clock edge: d_reg<=reqN_data, id_reg<=N, last_grant<=N, state->CONV.
  - With no valid request, stay in IDLE with both ready=0.
- CONV:
  - The converter sees d_reg.
  - Edge: out_s/out_e/out_f<=converter outputs, out_id<=id_reg, out_valid<=1, state->OUT.
- OUT:
  - out_* hold stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0, state->IDLE.
- reqN_ready is never high outside IDLE.
- Latency: request handshake at edge k → out_valid high after edge k+1. Minimum 3 cycles per sample.
- Requesters must hold valid and data stable until ready. A requester that drops valid before grant is simply not served.
- Converter semantics:
  - Input is magnitude/sign of the 12-bit two's-complement sample; magnitude of −2048 clamps to 2047.
  - E comes from the leading-zero count: ≥8 gives 0, then 7→1, 6→2 … 1→7.
  - F is the 4 bits at the exponent position, rounded up by the next bit.
  - Rounding overflow of F (1111+1) gives F=1000, E+1.
  - At E=7 the result saturates to F=1111.
- rst asserted in CONV or OUT: the in-flight result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro FPCONV_STATS_EN.
- Defined:
  - Adds output port conv_count[15:0], reset to 0.
  - Increments on each out_valid&&out_ready; wraps 0xFFFF→0x0000.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fpconv_pkg holds:
  - DATA_W/EXP_W/FRAC_W constants.
  - State localparams IDLE=2'd0, CONV=2'd1, OUT=2'd2.
  - Requester ID constants.
- Sub-module: the existing `floating_point_converter` is instantiated unchanged as the datapath.
- Arbitration and FSM stay in fpconv_rr_scheduler.

Test Plan:
- Reset: assert rst mid-clock → all outputs 0 immediately. After release, req1 alone with 12'h001 → req1_ready pulses; 2 cycles later out_valid=1, S=0, E=0, F=0001, id=1.
- Simultaneous: req0=12'h02C and req1=12'h02E both valid from reset.
  - First result: id=0, S=0, E=2, F=1011.
  - Second result: id=1, S=0, E=2, F=1100.
- Rounding carry and saturation:
  - 12'h07D → E=4, F=1000.
  - 12'h800 → S=1, E=7, F=1111.
  - 12'h7FF → S=0, E=7, F=1111.
- Backpressure: hold out_ready=0 for 10 cycles in OUT → out_* stable; both req*_ready stay 0. Raising out_ready → out_valid falls the next cycle.
- Reset mid-op: assert rst in CONV → no out_valid appears; the next contention grants req0 first.
- FPCONV_STATS_EN: 5 completed handshakes → conv_count=5. Preload by running 65536 handshakes → wraps to 0.
